// File: rtl/pcie_pkg.sv
// Shared PCIe transmit definitions: memory request header layout, TX FSM
// state and arbitration select encodings, and the header-length-to-beats helper.
package PCIE_PKG;

  localparam int BEAT_DW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } tx_state_e;

  typedef enum logic {
    SEL_P  = 1'b0,
    SEL_NP = 1'b1
  } tx_sel_e;

  // DW0 occupies bits [31:0]; the 10-bit length field sits at the bottom of DW0.
  typedef struct packed {
    logic [31:0] dw3;
    logic [31:0] dw2;
    logic [31:0] dw1;
    logic [2:0]  fmt;
    logic [4:0]  tlp_type;
    logic        t9;
    logic [2:0]  tc;
    logic        t8;
    logic        attr2;
    logic        ln;
    logic        th;
    logic        td;
    logic        ep;
    logic [1:0]  attr;
    logic [1:0]  at;
    logic [1:0]  length_h;
    logic [7:0]  length_l;
  } tlp_memory_req_hdr_t;

  // A length field of zero encodes 1024 DW, i.e. 128 beats.
  function automatic logic [7:0] beats_for_len(input logic [9:0] len);
    logic [10:0] dw;
    dw = (len == 10'd0) ? 11'd1024 : {1'b0, len};
    return 8'((dw + 11'(BEAT_DW - 1)) / 11'(BEAT_DW));
  endfunction

endpackage

// File: rtl/tl_tx_arbiter.sv
// Transaction-layer TX arbiter: picks posted or non-posted TLPs from the
// header FIFOs and streams header plus payload beats to the data link layer.
module tl_tx_arbiter
  import PCIE_PKG::*;
#(
  parameter int TX_DEPTH_LG2 = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    p_hdr_empty_i,
  input  logic [127:0]            p_hdr_rdata_i,
  output logic                    p_hdr_rden_o,
  input  logic                    p_data_empty_i,
  input  logic [255:0]            p_data_rdata_i,
  output logic                    p_data_rden_o,
  input  logic                    np_hdr_empty_i,
  input  logic [127:0]            np_hdr_rdata_i,
  output logic                    np_hdr_rden_o,
  input  logic [TX_DEPTH_LG2:0]   p_payload_cnt_i,
  output logic                    p_sent_o,
  input  logic                    fc_p_ok_i,
  input  logic                    fc_np_ok_i,
  output logic                    tlp_valid_o,
  input  logic                    tlp_ready_i,
  output logic [255:0]            tlp_data_o,
  output logic                    tlp_sop_o,
  output logic                    tlp_eop_o
);

  tx_state_e           state;
  tx_sel_e             sel;
  logic [7:0]          beat_cnt;
  tlp_memory_req_hdr_t hdr_sel;
  logic                p_elig;
  logic                np_elig;
  logic                hdr_accept;
  logic                data_accept;
  logic                last_beat;

  assign hdr_sel = (sel == SEL_NP) ? tlp_memory_req_hdr_t'(np_hdr_rdata_i)
                                   : tlp_memory_req_hdr_t'(p_hdr_rdata_i);

  // A queued posted header blocks NP even while it waits for payload or credit.
  assign p_elig      = ~p_hdr_empty_i & (p_payload_cnt_i != '0) & fc_p_ok_i;
  assign np_elig     = ~np_hdr_empty_i & fc_np_ok_i & p_hdr_empty_i;
  assign hdr_accept  = (state == HDR) & tlp_ready_i;
  assign data_accept = (state == DATA) & ~p_data_empty_i & tlp_ready_i;
  assign last_beat   = (beat_cnt == 8'd1);

  always_comb begin
    tlp_valid_o   = 1'b0;
    tlp_data_o    = '0;
    tlp_sop_o     = 1'b0;
    tlp_eop_o     = 1'b0;
    p_hdr_rden_o  = 1'b0;
    np_hdr_rden_o = 1'b0;
    p_data_rden_o = 1'b0;
    p_sent_o      = 1'b0;
    case (state)
      HDR: begin
        tlp_valid_o   = 1'b1;
        tlp_sop_o     = 1'b1;
        tlp_eop_o     = (sel == SEL_NP);
        tlp_data_o    = {128'b0, hdr_sel};
        p_hdr_rden_o  = hdr_accept & (sel == SEL_P) & ~p_hdr_empty_i;
        np_hdr_rden_o = hdr_accept & (sel == SEL_NP) & ~np_hdr_empty_i;
      end
      DATA: begin
        tlp_valid_o   = ~p_data_empty_i;
        tlp_data_o    = p_data_rdata_i;
        tlp_eop_o     = last_beat;
        p_data_rden_o = data_accept;
        p_sent_o      = data_accept & last_beat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= SEL_P;
      beat_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (p_elig) begin
            sel   <= SEL_P;
            state <= HDR;
          end else if (np_elig) begin
            sel   <= SEL_NP;
            state <= HDR;
          end
        end
        HDR: begin
          if (tlp_ready_i) begin
            if (sel == SEL_NP) begin
              state <= IDLE;
            end else begin
              state    <= DATA;
              beat_cnt <= beats_for_len({hdr_sel.length_h, hdr_sel.length_l});
            end
          end
        end
        DATA: begin
          if (data_accept) begin
            beat_cnt <= beat_cnt - 8'd1;
            if (last_beat) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tl_tx_arbiter.md
TL_TX_ARBITER -- requirements
Module: tl_tx_arbiter

Interface
REQ-001 SHALL have parameter TX_DEPTH_LG2, default 3, giving the width of the posted-payload count (TX_DEPTH_LG2+1 bits).
REQ-002 SHALL have clk  input  1  clock; all logic on its rising edge.
REQ-003 SHALL have rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have p_hdr_empty_i  input  1 / p_hdr_rdata_i  input  128 / p_hdr_rden_o  output  1; posted header FIFO, show-ahead head, pop on rden.
REQ-005 SHALL have p_data_empty_i  input  1 / p_data_rdata_i  input  256 / p_data_rden_o  output  1; posted payload FIFO, show-ahead, one 8DW beat per entry.
REQ-006 SHALL have np_hdr_empty_i  input  1 / np_hdr_rdata_i  input  128 / np_hdr_rden_o  output  1; non-posted header FIFO, show-ahead.
REQ-007 SHALL have p_payload_cnt_i  input  TX_DEPTH_LG2+1  number of complete posted payloads resident in the data FIFO.
REQ-008 SHALL have p_sent_o  output  1  one-cycle pulse when the last beat of a posted TLP is accepted.
REQ-009 SHALL have fc_p_ok_i  input  1 / fc_np_ok_i  input  1  link-partner credit available for a P / NP TLP.
REQ-010 SHALL have tlp_valid_o  output  1 / tlp_ready_i  input  1 / tlp_data_o  output  256 / tlp_sop_o  output  1 / tlp_eop_o  output  1  TLP beat stream to the data link layer.

Function
REQ-011 SHALL implement FSM states IDLE, HDR, DATA; the FSM SHALL start in IDLE.
REQ-012 In IDLE, P SHALL be eligible when ~p_hdr_empty_i & (p_payload_cnt_i != 0) & fc_p_ok_i.
REQ-013 In IDLE, NP SHALL be eligible only when np_hdr_empty_i is low, fc_np_ok_i is high, and p_hdr_empty_i is high; NP never passes a queued P, even one waiting on payload or credit.
REQ-014 P SHALL have strict priority: if P is eligible, latch sel=P and go to HDR; else if NP is eligible, latch sel=NP and go to HDR; else remain in IDLE.
REQ-015 In HDR, tlp_valid_o SHALL be 1, tlp_sop_o 1, tlp_data_o = {128'b0, selected header}, and tlp_eop_o = 1 only when sel=NP.
REQ-016 On HDR with tlp_ready_i, the selected hdr rden SHALL pulse for exactly that cycle; NP SHALL return to IDLE; P SHALL go to DATA with beat_cnt loaded.
REQ-017 beat_cnt (8 bits) SHALL be loaded as ceil(L/8), where L = {length_h,length_l} from the header; L=0 means 1024 DW, giving 128 beats.
REQ-018 In DATA, tlp_valid_o SHALL equal ~p_data_empty_i, tlp_data_o SHALL equal p_data_rdata_i, tlp_sop_o 0, and tlp_eop_o SHALL be 1 when beat_cnt==1.
REQ-019 On DATA with valid&ready, p_data_rden_o SHALL pulse and beat_cnt SHALL decrement; on the eop beat, p_sent_o SHALL pulse in the same cycle and the FSM SHALL go to IDLE.
REQ-020 Once tlp_valid_o is asserted in HDR it SHALL hold with stable data until accepted; credit inputs SHALL be sampled only in IDLE.
REQ-021 Minimum gap SHALL be one IDLE cycle between TLPs; an NP TLP SHALL occupy 2 cycles and a P TLP of N beats at least N+2 cycles.
REQ-022 tlp_ready_i low SHALL stall all state, with no FIFO pop and no counter change.
REQ-023 In any state, a FIFO rden SHALL never assert while that FIFO's empty input is high.

Reset
REQ-024 While rst_n is low at a clock edge, state SHALL become IDLE, sel P, beat_cnt 0, and all outputs SHALL be 0 (tlp_data_o 0) the following cycle.
REQ-025 Reset mid-TLP SHALL abandon the packet with no pop and no p_sent_o; FIFO flush is the owner's responsibility.

Structure
REQ-026 Header field extraction SHALL use PCIE_PKG::tlp_memory_req_hdr_t; the FSM state enum and localparam BEAT_DW=8 SHALL be added to PCIE_PKG.
REQ-027 The block SHALL be a single module with no sub-modules; FIFOs and the payload counter stay external.

Verification
REQ-028 NP only, L=16, ready=1 -> one beat with sop=eop=1 and header in [127:0], np_hdr_rden pulse, p_sent_o never asserted.
REQ-029 P hdr with L=24, payload_cnt=1, 3 data beats queued -> hdr beat + 3 beats, eop on the 3rd, p_sent_o one pulse with the 3rd beat, 3 data pops.
REQ-030 P and NP both queued -> P transmitted first; NP is held while p_payload_cnt_i=0 even with the NP credit high.
REQ-031 P with L=0 (1024 DW) -> 128 data beats, eop only on beat 128.
REQ-032 ready toggled randomly, and p_data_empty_i raised mid-payload -> no beat lost or duplicated, valid low while empty, data stable while stalled.
REQ-033 rst_n low in DATA after 2 of 4 beats -> next cycle IDLE, all outputs 0, no p_sent_o.
